// File: rtl/tx_pilot_insert_pkg.sv
// tx_pilot_insert_pkg: shared constants, FSM states and subcarrier mapping helpers for pilot insertion
package tx_pilot_insert_pkg;

    localparam int NUM_DATA   = 48;
    localparam int NUM_USED   = 52;
    localparam int NUM_PILOTS = 4;

    // Output beat indices carrying pilots (subcarriers -21, -7, +7, +21)
    localparam logic [5:0] PILOT_POS [NUM_PILOTS] = '{6'd5, 6'd19, 6'd32, 6'd46};

    // Bit i set means pilot i has base sign -1
    localparam logic [NUM_PILOTS-1:0] PILOT_NEG = 4'b1000;

    localparam logic [6:0] LFSR_SEED = 7'b111_1111;

    typedef enum logic [1:0] {
        COLLECT,
        EMIT,
        GAP
    } state_e;

    function automatic logic is_pilot(input logic [5:0] k);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_PILOTS; i++) hit = hit | (k == PILOT_POS[i]);
        return hit;
    endfunction

    function automatic logic pilot_neg(input logic [5:0] k);
        logic neg;
        neg = 1'b0;
        for (int i = 0; i < NUM_PILOTS; i++) neg = neg | ((k == PILOT_POS[i]) & PILOT_NEG[i]);
        return neg;
    endfunction

    // Buffer entry for a data beat: beat index minus the pilots already passed
    function automatic logic [5:0] data_idx(input logic [5:0] k);
        logic [5:0] n;
        n = k;
        for (int i = 0; i < NUM_PILOTS; i++) n = (k > PILOT_POS[i]) ? n - 6'd1 : n;
        return n;
    endfunction

endpackage

// File: rtl/tx_pilot_polarity_lfsr.sv
// tx_pilot_polarity_lfsr: x^7+x^4+1 pilot polarity sequence, polarity=1 means the pilot is negated
module tx_pilot_polarity_lfsr
    import tx_pilot_insert_pkg::*;
(
    input  logic clk_Modulation,
    input  logic reset_n,
    input  logic restart,
    input  logic advance,
    output logic polarity
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    assign polarity = lfsr_q[6] ^ lfsr_q[3];

    // Reload at packet start, otherwise shift once per finished symbol
    always_comb begin
        lfsr_d = restart ? LFSR_SEED : (advance ? {lfsr_q[5:0], polarity} : lfsr_q);
    end

    // Sequence state register, reseeded by reset
    always_ff @(posedge clk_Modulation) begin
        if (!reset_n) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/tx_pilot_insert.sv
// tx_pilot_insert: collects 48 data subcarriers, emits a 52-beat burst with pilots; TX_PILOT_POLARITY_EN enables pilot polarity scrambling
module tx_pilot_insert
    import tx_pilot_insert_pkg::*;
#(
    parameter logic [31:0] PILOT_AMP = 32'h0000_4000,
    parameter int          SYM_GAP   = 108
) (
    input  logic        clk_Modulation,
    input  logic        reset_n,
    input  logic [15:0] n_ofdm_syms,
    input  logic        data_valid,
    input  logic [31:0] data_re,
    input  logic [31:0] data_im,
    output logic        data_ready,
    output logic        tx_freqd_to_timed_valid,
    output logic [31:0] tx_freqd_to_timed_re,
    output logic [31:0] tx_freqd_to_timed_im,
    output logic        tx_pilot_sym_end,
    output logic        tx_pilot_pkt_end,
    output logic        err_overflow
);

    state_e      state_q;
    logic [31:0] buf_re_q [NUM_DATA];
    logic [31:0] buf_im_q [NUM_DATA];
    logic [5:0]  wr_idx_q;
    logic [15:0] cnt_q;
    logic [15:0] sym_q;
    logic        ready_q;
    logic        valid_q;
    logic [31:0] re_q;
    logic [31:0] im_q;
    logic        sym_end_q;
    logic        pkt_end_q;
    logic        ovf_q;

    logic        accept;
    logic        sym_done;
    logic        last_sym;
    logic [15:0] last_idx;
    logic        pol_neg;
    logic [5:0]  k_d;
    logic        pilot_d;
    logic [31:0] re_d;
    logic [31:0] im_d;

    assign accept   = data_valid & ready_q;
    assign last_idx = (n_ofdm_syms == 16'd0) ? 16'd0 : n_ofdm_syms - 16'd1;
    assign last_sym = (sym_q == last_idx);
    assign sym_done = (state_q == EMIT) && (cnt_q == 16'(NUM_USED - 1));

`ifdef TX_PILOT_POLARITY_EN
    tx_pilot_polarity_lfsr u_polarity (
        .clk_Modulation (clk_Modulation),
        .reset_n        (reset_n),
        .restart        (sym_done & last_sym),
        .advance        (sym_done & ~last_sym),
        .polarity       (pol_neg)
    );
`else
    assign pol_neg = 1'b0;
`endif

    // Value of the beat to be registered next: k=0 on burst start, k+1 while emitting
    always_comb begin
        k_d     = (state_q == EMIT && !sym_done) ? cnt_q[5:0] + 6'd1 : 6'd0;
        pilot_d = is_pilot(k_d);
        re_d    = pilot_d ? ((pilot_neg(k_d) ^ pol_neg) ? -PILOT_AMP : PILOT_AMP) : buf_re_q[data_idx(k_d)];
        im_d    = pilot_d ? 32'd0 : buf_im_q[data_idx(k_d)];
    end

    // Data buffer written in arrival order; contents need no reset
    always_ff @(posedge clk_Modulation) begin
        if (accept) begin
            buf_re_q[wr_idx_q] <= data_re;
            buf_im_q[wr_idx_q] <= data_im;
        end
    end

    // Collect / emit / gap sequencing with registered outputs
    always_ff @(posedge clk_Modulation) begin
        if (!reset_n) begin
            state_q   <= COLLECT;
            wr_idx_q  <= '0;
            cnt_q     <= '0;
            sym_q     <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            re_q      <= '0;
            im_q      <= '0;
            sym_end_q <= 1'b0;
            pkt_end_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (data_valid && !ready_q) ovf_q <= 1'b1;
            case (state_q)
                COLLECT: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        wr_idx_q <= wr_idx_q + 6'd1;
                        if (wr_idx_q == 6'(NUM_DATA - 1)) begin
                            state_q  <= EMIT;
                            ready_q  <= 1'b0;
                            wr_idx_q <= '0;
                            cnt_q    <= '0;
                            valid_q  <= 1'b1;
                            re_q     <= re_d;
                            im_q     <= im_d;
                        end
                    end
                end
                EMIT: begin
                    if (sym_done) begin
                        state_q   <= GAP;
                        cnt_q     <= '0;
                        valid_q   <= 1'b0;
                        re_q      <= '0;
                        im_q      <= '0;
                        sym_end_q <= 1'b0;
                        pkt_end_q <= 1'b0;
                        sym_q     <= last_sym ? 16'd0 : sym_q + 16'd1;
                    end else begin
                        cnt_q     <= cnt_q + 16'd1;
                        re_q      <= re_d;
                        im_q      <= im_d;
                        sym_end_q <= (k_d == 6'(NUM_USED - 1));
                        pkt_end_q <= (k_d == 6'(NUM_USED - 1)) && last_sym;
                    end
                end
                GAP: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == 16'(SYM_GAP - 1)) begin
                        state_q <= COLLECT;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign data_ready              = ready_q;
    assign tx_freqd_to_timed_valid = valid_q;
    assign tx_freqd_to_timed_re    = re_q;
    assign tx_freqd_to_timed_im    = im_q;
    assign tx_pilot_sym_end        = sym_end_q;
    assign tx_pilot_pkt_end        = pkt_end_q;
    assign err_overflow            = ovf_q;

endmodule

// File: tb/tb_tx_pilot_insert.sv
// tb_tx_pilot_insert: scoreboard bench for tx_pilot_insert, pilot polarity expectations follow TX_PILOT_POLARITY_EN
module tb_tx_pilot_insert;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic        se;
        logic        pe;
    } beat_t;

`ifdef TX_PILOT_POLARITY_EN
    localparam bit POL_EN = 1'b1;
`else
    localparam bit POL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] n_ofdm_syms;
    logic        data_valid;
    logic [31:0] data_re;
    logic [31:0] data_im;
    logic        data_ready;
    logic        tx_valid;
    logic [31:0] tx_re;
    logic [31:0] tx_im;
    logic        sym_end;
    logic        pkt_end;
    logic        err_overflow;

    beat_t       sb[$];
    logic [31:0] d_re [48];
    logic [31:0] d_im [48];
    int          compared = 0;
    int          mismatched = 0;

    tx_pilot_insert dut (
        .clk_Modulation          (clk),
        .reset_n                 (reset_n),
        .n_ofdm_syms             (n_ofdm_syms),
        .data_valid              (data_valid),
        .data_re                 (data_re),
        .data_im                 (data_im),
        .data_ready              (data_ready),
        .tx_freqd_to_timed_valid (tx_valid),
        .tx_freqd_to_timed_re    (tx_re),
        .tx_freqd_to_timed_im    (tx_im),
        .tx_pilot_sym_end        (sym_end),
        .tx_pilot_pkt_end        (pkt_end),
        .err_overflow            (err_overflow)
    );

    always #5 clk = ~clk;

    // 802.11 pilot polarity p_0..p_7 = +1 +1 +1 +1 -1 -1 -1 +1 (bit set = negative)
    function automatic logic pol_neg(input int s);
        logic [7:0] t;
        t = 8'b0111_0000;
        return POL_EN && (s < 8) && t[s[2:0]];
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 48; i++) begin
            d_re[i] = rnd ? $urandom : 32'(i + 1);
            d_im[i] = rnd ? $urandom : 32'(-(i + 1));
        end
    endtask

    // Expected burst built by walking subcarriers -26..+26 and skipping DC
    task automatic push_sym(input int s, input int n);
        int    di;
        int    pi;
        int    lastsym;
        beat_t b;
        di = 0;
        pi = 0;
        lastsym = (n == 0) ? 0 : n - 1;
        for (int sc = -26; sc <= 26; sc++) begin
            if (sc != 0) begin
                if (sc == -21 || sc == -7 || sc == 7 || sc == 21) begin
                    b.re = ((pi == 3) ^ pol_neg(s)) ? 32'hFFFF_C000 : 32'h0000_4000;
                    b.im = 32'h0;
                    pi++;
                end else begin
                    b.re = d_re[di];
                    b.im = d_im[di];
                    di++;
                end
                b.se = (sc == 26);
                b.pe = (sc == 26) && (s == lastsym);
                sb.push_back(b);
            end
        end
    endtask

    // Called and returns #1 after a rising edge
    task automatic send_beat(input logic [31:0] re, input logic [31:0] im);
        int g;
        g = 0;
        while (data_ready !== 1'b1 && g < 2000) begin
            data_valid = 1'b0;
            @(posedge clk);
            #1;
            g++;
        end
        chk("ready_wait", 128'(g < 2000), 128'(1));
        data_valid = 1'b1;
        data_re = re;
        data_im = im;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input bit toggle);
        for (int i = 0; i < 48; i++) begin
            send_beat(d_re[i], d_im[i]);
            if (toggle) begin
                data_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("drain", 128'(sb.size()), 128'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        int    cyc;
        int    acc;
        int    exp_rise;
        int    last_rise;
        logic  prev;
        beat_t got;
        beat_t exp;
        cyc = 0;
        acc = 0;
        exp_rise = -1;
        last_rise = -1;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            got = {tx_re, tx_im, sym_end, pkt_end};
            if (tx_valid === 1'b1) begin
                if (!prev) begin
                    chk("rise_cycle", 128'(cyc), 128'(exp_rise));
                    if (last_rise >= 0) chk("rise_spacing_ge_160", 128'((cyc - last_rise) >= 160), 128'(1));
                    last_rise = cyc;
                end
                chk("beat_expected", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    chk("beat", 128'(got), 128'(exp));
                end
            end else begin
                chk("idle_zero", 128'(got), 128'(0));
            end
            prev = (tx_valid === 1'b1);
            if (reset_n !== 1'b1) begin
                acc = 0;
                last_rise = -1;
            end else if (data_valid && data_ready) begin
                acc++;
                if (acc == 48) begin
                    acc = 0;
                    exp_rise = cyc + 1;
                end
            end
        end
    endtask

    initial begin
        int g;
        reset_n = 1'b0;
        n_ofdm_syms = 16'd6;
        data_valid = 1'b0;
        data_re = '0;
        data_im = '0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 128'({data_ready, tx_valid, tx_re, tx_im, sym_end, pkt_end, err_overflow}), 128'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 128'(data_ready), 128'(1));

        for (int s = 0; s < 6; s++) begin
            fill(s >= 2);
            push_sym(s, 6);
            send_sym(s == 1);
            if (s == 1) begin
                drain();
                chk("no_overflow", 128'(err_overflow), 128'(0));
            end
            if (s == 3) begin
                data_valid = 1'b1;
                data_re = 32'hDEAD_0001;
                data_im = 32'hBEEF_0002;
                @(posedge clk);
                #1;
                data_valid = 1'b0;
                chk("overflow_set", 128'(err_overflow), 128'(1));
            end
        end
        drain();

        n_ofdm_syms = 16'd8;
        for (int s = 0; s < 6; s++) begin
            fill(1'b1);
            push_sym(s, 8);
            send_sym(1'b0);
        end
        @(negedge clk);
        g = 0;
        while (tx_valid !== 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("burst_start", 128'(tx_valid), 128'(1));
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_state", 128'({tx_valid, data_ready, err_overflow}), 128'(0));
        #1;
        reset_n = 1'b1;
        sb.delete();

        n_ofdm_syms = 16'd2;
        for (int s = 0; s < 2; s++) begin
            fill(1'b1);
            push_sym(s, 2);
            send_sym(1'b0);
        end
        drain();

        n_ofdm_syms = 16'd0;
        for (int s = 0; s < 2; s++) begin
            fill(1'b1);
            push_sym(0, 0);
            send_sym(1'b0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
